// File: rtl/mul_div_unit_if.sv
// Bundles the request and response signals of the multiply/divide unit.
// The master drives the operation request and the MTHI/MTLO writes.
// The slave returns busy, done and the HI/LO registers.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, A, B, hi_we, lo_we, wdata,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, wdata,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO registers.
// Multiply uses radix-2 shift-add. Divide uses restoring shift-subtract on
// magnitudes, and the signs are fixed up in the FIX state.
// Optional feature macro MDU_EARLY_TERM_EN: a multiply leaves CALC as soon as
// the remaining multiplier bits are zero, and FIX realigns the accumulator.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mul_div_unit_if.slave        bus
);
    localparam int              CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   W_LAST = CW'(WIDTH - 1);
`ifdef MDU_EARLY_TERM_EN
    localparam logic [CW-1:0]   W_CNT  = CW'(WIDTH);
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;        // |A| (multiplicand / dividend shifter), raw A on divide-by-zero
    logic [WIDTH-1:0]   r_b;        // |B| (multiplier shifter / divisor)
    logic [2*WIDTH-1:0] r_acc;      // product, or {remainder, quotient}
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_div0;
    logic               r_neg_lo;   // negate product / quotient
    logic               r_neg_hi;   // negate remainder
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    // Operand decode for the IDLE launch
    logic             w_signed_op;
    logic             w_div_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic             w_div0;

    assign w_signed_op = ~bus.op[0];
    assign w_div_op    = bus.op[1];
    assign w_a_neg     = w_signed_op & bus.A[WIDTH-1];
    assign w_b_neg     = w_signed_op & bus.B[WIDTH-1];
    assign w_a_abs     = w_a_neg ? -bus.A : bus.A;
    assign w_b_abs     = w_b_neg ? -bus.B : bus.B;
    assign w_div0      = w_div_op & (bus.B == '0);

    // One multiply step: add the multiplicand into the high half, then shift right
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : '0)};
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // One divide step: shift the next dividend bit into the remainder, then trial-subtract
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_acc;
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_div_ok    = ~w_div_diff[WIDTH];
    assign w_div_acc   = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ok};

    // Last CALC step detection
    logic w_last;
`ifdef MDU_EARLY_TERM_EN
    assign w_last = (r_cnt == W_LAST) | (~r_is_div & (r_b[WIDTH-1:1] == '0));
`else
    assign w_last = (r_cnt == W_LAST);
`endif

    // Result formatting used in FIX
    logic [2*WIDTH-1:0] w_mul_aligned;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
`ifdef MDU_EARLY_TERM_EN
    assign w_mul_aligned = r_acc >> (W_CNT - r_cnt);
`else
    assign w_mul_aligned = r_acc;
`endif
    assign w_prod = r_neg_lo ? -w_mul_aligned : w_mul_aligned;
    assign w_quot = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // Control FSM, datapath registers and HI/LO ownership
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_is_div <= w_div_op;
                        r_div0   <= w_div0;
                        r_a      <= w_div0 ? bus.A : w_a_abs;
                        r_b      <= w_b_abs;
                        r_neg_lo <= w_a_neg ^ w_b_neg;
                        r_neg_hi <= w_a_neg;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= w_div0 ? S_FIX : S_CALC;
                    end else begin
                        if (bus.hi_we) r_hi <= bus.wdata;
                        if (bus.lo_we) r_lo <= bus.wdata;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc <= w_div_acc;
                        r_a   <= r_a << 1;
                    end else begin
                        r_acc <= w_mul_acc;
                        r_b   <= r_b >> 1;
                    end
                    if (w_last) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_div0) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO and the
// done cycle into a queue; the monitor pops and compares on every done pulse.
module tb_mul_div_unit;
    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_hi"}, bus.HI, e.hi);
                chk({e.name, "_lo"}, bus.LO, e.lo);
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                $display("txn %s: HI=%h LO=%h cycle=%0d", e.name, bus.HI, bus.LO, cyc);
            end
        end
    end

    // Launch one op; returns after the sampling edge k
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.cyc = cyc + lat; e.name = name;
            exp_q.push_back(e);
            last_hi = ehi;
            last_lo = elo;
        end
    endtask

    // Wait (bounded) for done; optionally check number of busy cycles
    task automatic wait_done(input string name, input int lat, input bit chk_busy);
        int n;
        int bc;
        n  = 0;
        bc = 0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) bc++;
            n++;
            if (n > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
                return;
            end
        end
        if (chk_busy) chk({name, "_busy_cycles"}, 32'(bc), 32'(lat));
        chk({name, "_busy_after_done"}, {31'b0, bus.busy}, 32'h0);
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int lat);
        issue(name, op, a, b, ehi, elo, lat, 1'b1);
        wait_done(name, lat, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'b0, bus.busy}, 32'h0);
        chk("reset_done", {31'b0, bus.done}, 32'h0);
        chk("reset_hi", bus.HI, 32'h0);
        chk("reset_lo", bus.LO, 32'h0);
        reset = 1'b1;

        run("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
        run("mult_m3x7",  2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
        run("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33);
        run("div_m7d2",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run("div_7dm2",   2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
        run("divu_100d7", 2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       33);
        run("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
        run("divu_max1",  2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 33);
        run("divu_by0",   2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1);
        run("div_by0",    2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1);

        // MTHI, MTLO and both together in IDLE; none may pulse done
        @(negedge clk);
        bus.hi_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
        @(negedge clk);
        bus.hi_we = 1'b0;
        chk("mthi_hi", bus.HI, 32'hA5A5A5A5);
        chk("mthi_lo_hold", bus.LO, last_lo);
        bus.lo_we = 1'b1; bus.wdata = 32'h5A5A0001;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo_lo", bus.LO, 32'h5A5A0001);
        chk("mtlo_hi_hold", bus.HI, 32'hA5A5A5A5);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0BADF00D;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("mthilo_hi", bus.HI, 32'h0BADF00D);
        chk("mthilo_lo", bus.LO, 32'h0BADF00D);
        $display("txn mthi_mtlo: HI=%h LO=%h", bus.HI, bus.LO);

        // start together with hi_we in IDLE: start wins, write dropped
        bus.hi_we = 1'b1; bus.wdata = 32'hCAFEF00D;
        issue("start_hiwe", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1);
        bus.hi_we = 1'b0;
        wait_done("start_hiwe", 33, 1'b1);

        // start and hi_we while busy are ignored
        issue("busy_ignore", 2'b01, 32'h00010000, 32'h00010001, 32'h00000001, 32'h00010000, 33, 1'b1);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.A = 32'd50; bus.B = 32'd3;
        bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0;
        chk("busy_ignore_hi_hold", bus.HI, 32'd2);
        wait_done("busy_ignore", 33, 1'b0);

        // Reset in the middle of a divide aborts it silently
        issue("div_abort", 2'b10, 32'hFFFFFF9C, 32'd3, 32'h0, 32'h0, 33, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, bus.busy}, 32'h0);
        chk("abort_done", {31'b0, bus.done}, 32'h0);
        chk("abort_hi", bus.HI, 32'h0);
        chk("abort_lo", bus.LO, 32'h0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_late_busy", {31'b0, bus.busy}, 32'h0);
        run("after_abort", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
